// File: rtl/coffee_io_pkg.sv
// Shared types and constants for the coffee machine input front end.
package coffee_io_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btn_state_t;

    localparam int CH_NEXT   = 0;
    localparam int CH_SELECT = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchronizer, debounce FSM with a saturating
// stability counter, registered level/press-pulse outputs and, when
// BTN_AUTOREPEAT_EN is defined, a hold-to-repeat timer.
module btn_debounce_ch
    import coffee_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 20000000,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    // With a one-cycle debounce the first stable sample is already enough.
    localparam bit              FAST     = (DEBOUNCE_CYCLES == 1);

    logic           sync_q1;
    logic           s;
    btn_state_t     state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic           level_n, pulse_n;
    logic           rpt_fire;

    // Two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q1 <= 1'b0;
            s       <= 1'b0;
        end else begin
            sync_q1 <= raw;
            s       <= sync_q1;
        end
    end

    // Debounce FSM state, counter and outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            level <= level_n;
            pulse <= pulse_n | rpt_fire;
        end
    end

    // Next state: count consecutive stable samples, fall back on any glitch.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        level_n = level;
        pulse_n = 1'b0;
        case (state)
            IDLE: begin
                if (s) begin
                    if (FAST) begin
                        state_n = PRESSED;
                        cnt_n   = '0;
                        level_n = 1'b1;
                        pulse_n = 1'b1;
                    end else begin
                        state_n = PRESS_WAIT;
                        cnt_n   = CNT_ONE;
                    end
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = PRESSED;
                    cnt_n   = '0;
                    level_n = 1'b1;
                    pulse_n = 1'b1;
                end else if (cnt != '1) begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!s) begin
                    if (FAST) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        level_n = 1'b0;
                    end else begin
                        state_n = RELEASE_WAIT;
                        cnt_n   = CNT_ONE;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_n = PRESSED;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    level_n = 1'b0;
                end else if (cnt != '1) begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    logic [RW-1:0] rpt, rpt_n;
    logic          rpt_first, rpt_first_n;

    // Repeat timer: restarts on every entry to PRESSED (including a bounce
    // back from RELEASE_WAIT), first gap REPEAT_DELAY, then REPEAT_PERIOD.
    always_comb begin
        rpt_n       = rpt;
        rpt_first_n = rpt_first;
        rpt_fire    = 1'b0;
        if (state_n != PRESSED) begin
            rpt_n       = '0;
            rpt_first_n = 1'b1;
        end else if (state != PRESSED) begin
            rpt_n       = RW'(1);
            rpt_first_n = 1'b1;
        end else if (REPEAT_EN) begin
            if (rpt == (rpt_first ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD))) begin
                rpt_fire    = 1'b1;
                rpt_n       = RW'(1);
                rpt_first_n = 1'b0;
            end else if (rpt != '1) begin
                rpt_n = rpt + RW'(1);
            end
        end
    end

    // Repeat timer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rpt       <= '0;
            rpt_first <= 1'b1;
        end else begin
            rpt       <= rpt_n;
            rpt_first <= rpt_first_n;
        end
    end
`else
    // No repeat hardware in this build; the repeat settings are inert.
    logic unused_rpt_cfg;
    assign unused_rpt_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD, REPEAT_EN};
    assign rpt_fire       = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: NUM_BUTTONS independent debounce channels turning
// raw pins into a clean level and a one-cycle press pulse each.
// Optional hold-to-repeat on REPEAT_MASK channels via BTN_AUTOREPEAT_EN.
module button_conditioner
    import coffee_io_pkg::*;
#(
    parameter int                     NUM_BUTTONS     = 2,
    parameter int                     DEBOUNCE_CYCLES = 500000,
    parameter int                     REPEAT_DELAY    = 50000000,
    parameter int                     REPEAT_PERIOD   = 20000000,
    parameter logic [NUM_BUTTONS-1:0] REPEAT_MASK     = NUM_BUTTONS'(1 << CH_NEXT)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] btn_raw,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] btn_pulse
);

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (REPEAT_MASK[i])
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .raw   (btn_raw[i]),
            .level (btn_level[i]),
            .pulse (btn_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random bouncing
// input, every cycle compared against a sample-window reference model.
module tb_button_conditioner;

    localparam int NB = 2;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_pulse;

    always #5 clk = ~clk;

    button_conditioner #(
        .NUM_BUTTONS     (NB),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .REPEAT_MASK     (2'b01)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: raw samples per edge; the level flips once the D
    // samples two edges back all disagree with it.
    int            hist [NB][D+2];
    logic [NB-1:0] m_level, m_pulse, m_inp;
    int            hold [NB];
    int            edge_no = 0;
    int            pcnt [NB];
    int            last_pe [NB];

    task automatic model_clear();
        for (int c = 0; c < NB; c++) begin
            for (int j = 0; j < D + 2; j++) hist[c][j] = 0;
            hold[c] = -1;
        end
        m_level = '0;
        m_pulse = '0;
        m_inp   = '0;
    endtask

    task automatic model_edge();
        bit all_opp;
        bit inp;
        edge_no++;
        for (int c = 0; c < NB; c++) begin
            for (int j = D + 1; j > 0; j--) hist[c][j] = hist[c][j-1];
            hist[c][0] = int'(btn_raw[c]);
            m_pulse[c] = 1'b0;
            all_opp = 1'b1;
            for (int j = 2; j <= D + 1; j++)
                if (hist[c][j] == int'(m_level[c])) all_opp = 1'b0;
            if (all_opp) begin
                m_level[c] = ~m_level[c];
                if (m_level[c]) m_pulse[c] = 1'b1;
            end
            inp = m_level[c] && (hist[c][2] == 1);
            if (inp) hold[c] = m_inp[c] ? hold[c] + 1 : 0;
            else     hold[c] = -1;
`ifdef BTN_AUTOREPEAT_EN
            if (inp && c == 0 && hold[c] >= RD && ((hold[c] - RD) % RP) == 0)
                m_pulse[c] = 1'b1;
`endif
            m_inp[c] = inp;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_edge();
        @(negedge clk);
        chk("level", 32'(btn_level), 32'(m_level));
        chk("pulse", 32'(btn_pulse), 32'(m_pulse));
        for (int c = 0; c < NB; c++)
            if (btn_pulse[c]) begin
                pcnt[c]++;
                last_pe[c] = edge_no;
            end
    endtask

    task automatic clr_cnt();
        for (int c = 0; c < NB; c++) begin
            pcnt[c]    = 0;
            last_pe[c] = -1000;
        end
    endtask

    initial begin
        int n0;
        int fe;
        int seg [NB];
        int exp_rep;

        model_clear();
        clr_cnt();
        #12;
        chk("rst_out", 32'({btn_level, btn_pulse}), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) step();

        // 1: clean press and release latency
        clr_cnt();
        btn_raw[0] = 1'b1;
        n0 = edge_no + 1;
        repeat (20) step();
        chk("t1_cnt", 32'(pcnt[0]), 32'd1);
        chk("t1_lat", 32'(last_pe[0] - n0), 32'(D + 1));
        btn_raw[0] = 1'b0;
        n0 = edge_no + 1;
        fe = -1;
        repeat (12) begin
            step();
            if (fe < 0 && !btn_level[0]) fe = edge_no;
        end
        chk("t1_rel", 32'(fe - n0), 32'(D + 1));

        // 2: bounce on select, then steady press
        clr_cnt();
        repeat (2) begin
            btn_raw[1] = 1'b1; repeat (2) step();
            btn_raw[1] = 1'b0; repeat (2) step();
        end
        chk("t2_bounce", 32'(pcnt[1]), 32'd0);
        btn_raw[1] = 1'b1;
        n0 = edge_no + 1;
        repeat (15) step();
        chk("t2_cnt", 32'(pcnt[1]), 32'd1);
        chk("t2_lat", 32'(last_pe[1] - n0), 32'(D + 1));
        btn_raw[1] = 1'b0;
        repeat (10) step();

        // 3: short glitch is ignored
        clr_cnt();
        btn_raw[0] = 1'b1;
        repeat (3) step();
        btn_raw[0] = 1'b0;
        repeat (10) step();
        chk("t3_cnt", 32'(pcnt[0]), 32'd0);

        // 4: simultaneous press
        clr_cnt();
        btn_raw = 2'b11;
        n0 = edge_no + 1;
        repeat (10) step();
        chk("t4_lat0", 32'(last_pe[0] - n0), 32'(D + 1));
        chk("t4_lat1", 32'(last_pe[1] - n0), 32'(D + 1));
        chk("t4_cnt", 32'(pcnt[0] + pcnt[1]), 32'd2);
        btn_raw = 2'b00;
        repeat (10) step();

        // 5: reset while pressed, button still held afterwards
        btn_raw[0] = 1'b1;
        repeat (10) step();
        chk("t5_pre", 32'(btn_level[0]), 32'd1);
        reset = 1'b0;
        #1;
        chk("t5_rst", 32'({btn_level, btn_pulse}), 32'h0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        clr_cnt();
        n0 = edge_no + 1;
        repeat (10) step();
        chk("t5_cnt", 32'(pcnt[0]), 32'd1);
        chk("t5_lat", 32'(last_pe[0] - n0), 32'(D + 1));
        btn_raw[0] = 1'b0;
        repeat (10) step();

        // 6: long hold on both channels
        clr_cnt();
        btn_raw = 2'b11;
        repeat (40) step();
        btn_raw = 2'b00;
        repeat (15) step();
`ifdef BTN_AUTOREPEAT_EN
        exp_rep = 7;
`else
        exp_rep = 1;
`endif
        chk("t6_next", 32'(pcnt[0]), 32'(exp_rep));
        chk("t6_sel", 32'(pcnt[1]), 32'd1);

        // random bouncing on both channels
        for (int c = 0; c < NB; c++) seg[c] = 1;
        repeat (600) begin
            for (int c = 0; c < NB; c++) begin
                seg[c]--;
                if (seg[c] == 0) begin
                    btn_raw[c] = 1'($urandom_range(0, 1));
                    seg[c] = int'($urandom_range(1, 3 * D));
                end
            end
            step();
        end
        btn_raw = 2'b00;
        repeat (12) step();
        chk("end_level", 32'(btn_level), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
